// File: rtl/fetch_queue.sv
// Instruction-byte prefetch queue: issues single-byte reads and buffers returns for the decoder.
// Latency: request to push is one cycle. mem_req is withheld when the queue plus the in-flight byte would overflow.
module fetch_queue #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0010
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_addr,
  input  logic                    bus_grant,
  output logic                    mem_req,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [ADDR_WIDTH-1:0]   head_addr,
  output logic                    head_valid,
  output logic [$clog2(DEPTH):0]  count,
  output logic [ADDR_WIDTH-1:0]   fetch_addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   addr_mem [DEPTH];
  logic [PW-1:0]           rd_ptr;
  logic [PW-1:0]           wr_ptr;
  logic                    in_flight;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [CW:0]             occupancy;
  logic                    push;
  logic                    do_pop;

  // The in-flight byte already owns a slot, so it counts toward occupancy.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, in_flight};
  assign mem_req    = !reset && !redirect && (state == RUN) && bus_grant && (occupancy < DEPTH_C);
  assign mem_addr   = fetch_addr;
  assign push       = in_flight && !redirect;
  assign do_pop     = pop && (count != '0) && !redirect;
  assign head_data  = data_mem[rd_ptr];
  assign head_addr  = addr_mem[rd_ptr];
  assign head_valid = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      in_flight  <= 1'b0;
      req_addr   <= '0;
      fetch_addr <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else begin
      in_flight <= mem_req;
      if (mem_req) req_addr <= fetch_addr;

      if (redirect) begin
        // Flush everything, including a return that would land this edge.
        state      <= RUN;
        fetch_addr <= redirect_addr;
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        if (mem_req) fetch_addr <= fetch_addr + ADDR_WIDTH'(1);

        case (state)
          IDLE: if (start) begin
            state      <= RUN;
            fetch_addr <= RESET_PC;
          end
          RUN:   if (halt) state <= DRAIN;
          DRAIN: if (!in_flight) state <= IDLE;
          default: state <= IDLE;
        endcase

        if (push) begin
          data_mem[wr_ptr] <= mem_rdata;
          addr_mem[wr_ptr] <= req_addr;
          wr_ptr           <= wr_ptr + PW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PW'(1);

        case ({push, do_pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning width of one instruction byte.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, >= 2.
REQ-004 SHALL have parameter RESET_PC, default 16'h0010, meaning the first fetch address after start.
REQ-005 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  begin fetching from RESET_PC while IDLE.
REQ-008 SHALL have port halt  in  1  stop issuing requests and return to IDLE once drained.
REQ-009 SHALL have port redirect  in  1  flush the queue and restart fetching at redirect_addr.
REQ-010 SHALL have port redirect_addr  in  ADDR_WIDTH  new fetch address (jump or branch target).
REQ-011 SHALL have port bus_grant  in  1  memory port available to the fetcher this cycle.
REQ-012 SHALL have port mem_req  out  1  read request; it is accepted in any cycle it is high.
REQ-013 SHALL have port mem_addr  out  ADDR_WIDTH  read address; equals fetch_addr.
REQ-014 SHALL have port mem_rdata  in  DATA_WIDTH  read data, valid the cycle after an accepted request.
REQ-015 SHALL have port pop  in  1  decoder consumes the head entry.
REQ-016 SHALL have port head_data  out  DATA_WIDTH  oldest queued byte.
REQ-017 SHALL have port head_addr  out  ADDR_WIDTH  memory address of head_data.
REQ-018 SHALL have port head_valid  out  1  queue non-empty.
REQ-019 SHALL have port count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-020 SHALL have port fetch_addr  out  ADDR_WIDTH  next address to be requested.

Function
REQ-021 SHALL implement states IDLE, RUN and DRAIN.
REQ-022 SHALL make the IDLE->RUN transition on start, loading fetch_addr=RESET_PC.
REQ-023 SHALL make the RUN->DRAIN transition on halt.
REQ-024 SHALL make the DRAIN->IDLE transition when no request is in flight.
REQ-025 SHALL accept redirect in any state: it enters RUN and loads fetch_addr=redirect_addr.
REQ-026 SHALL give redirect priority over halt and start in the same cycle.
REQ-027 SHALL drive mem_req combinationally and assert it only when: state==RUN, bus_grant=1, (count + in_flight) < DEPTH, and redirect=0.
REQ-028 SHALL increment fetch_addr by 1 on each accepted request, wrapping from 2^ADDR_WIDTH-1 to 0.
REQ-029 SHALL register one in-flight flag plus the requested address; the returning mem_rdata is pushed with that address at the following edge.
REQ-030 SHALL give a one-cycle latency from request to push; with continuous bus_grant and pops, it SHALL sustain one byte per cycle.
REQ-031 SHALL handle simultaneous push and pop: count unchanged, head advances, new byte appended.
REQ-032 SHALL ignore pop when empty, with no state change.
REQ-033 SHALL never issue a request that could overflow the queue when full, counting the in-flight byte.
REQ-034 SHALL, on redirect: set count to 0, reset pointers, discard any in-flight return, and ignore a same-cycle pop; the first new request SHALL be issued the cycle after.
REQ-035 SHALL let DRAIN accept the outstanding return and pops, with no new requests.
REQ-036 SHALL keep queue contents when entering IDLE, so pops continue in IDLE.
REQ-037 SHALL present head_data/head_addr registered from storage, and hold them stable while head_valid=1 and pop=0.
REQ-038 SHALL treat head_data/head_addr as don't-care when head_valid=0.

Reset
REQ-039 SHALL, on reset=1 at a rising edge: enter IDLE, count=0, head_valid=0, in-flight cleared, fetch_addr=RESET_PC, head_data=0, head_addr=0.
REQ-040 SHALL hold mem_req=0 while reset is high.
REQ-041 SHALL give reset priority over redirect, start and pop; a mid-flight return SHALL be discarded.

Verification
REQ-042 SHALL cover start: mem holds A9,04,85,02 at 0x10-0x13; pulse start, bus_grant=1, no pop -> mem_req issues to 0x10..0x13 on consecutive cycles, then stops; count=4; head_data=A9, head_addr=0x0010; first head_valid at the second edge after start.
REQ-043 SHALL cover streaming: pop held high every cycle after first valid -> bytes A9,04,85,02,... are delivered one per cycle in address order, and count stays at 1.
REQ-044 SHALL cover redirect: redirect while an in-flight request exists, redirect_addr=0x0002 -> the stale byte is not queued, count=0 next cycle, and the next head is mem[0x0002] with head_addr=0x0002.
REQ-045 SHALL cover backpressure and wrap: bus_grant toggled 1/0 every cycle, start from redirect_addr=0xFFFE -> requests go to 0xFFFE, 0xFFFF, 0x0000, issued only on grant cycles, with no lost or duplicated bytes.
REQ-046 SHALL cover halt: halt with one request in flight -> state DRAIN, the byte is still pushed, then IDLE; no mem_req afterwards; remaining entries are still poppable.
REQ-047 SHALL cover reset mid-operation: reset asserted with queue at 3 entries and a request in flight -> next cycle count=0, head_valid=0, fetch_addr=0x0010, no push.
